// File: rtl/mem_bus_if.sv
// CPU data-port bus and character output stream for mem_bus.
// master = CPU/consumer side, slave = mem_bus.
interface mem_bus_if;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        done;

    modport master (
        output Addr, WriteData, MemWrite, out_ready,
        input  ReadData, out_data, out_valid, done
    );

    modport slave (
        input  Addr, WriteData, MemWrite, out_ready,
        output ReadData, out_data, out_valid, done
    );
endinterface

// File: rtl/mem_bus.sv
// Data RAM, TX character FIFO, STATUS and DONE registers on the CPU data bus.
// Define MEM_BUS_OVERFLOW_EN to build the sticky FIFO overflow flag.
module mem_bus #(
    parameter int N          = 6,
    parameter int FIFO_DEPTH = 8
) (
    input logic     clk,
    input logic     rst,
    mem_bus_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [31:0]   ram_q [2**N];
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          ovf;

    logic          ram_sel, tx_sel, stat_sel, done_sel;
    logic          empty, full;
    logic          push_req, push, pop, drop;
    logic [N-1:0]  idx;
    logic [31:0]   rdata;
    logic          unused_addr;

    assign unused_addr = ^bus.Addr[1:0];

    assign ram_sel  = (bus.Addr[31:8] == 24'd0);
    assign tx_sel   = (bus.Addr[31:2] == 30'h40);
    assign stat_sel = (bus.Addr[31:2] == 30'h41);
    assign done_sel = (bus.Addr[31:2] == 30'h42);
    assign idx      = bus.Addr[N+1:2];

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == DEPTH_C);
    assign pop      = ~empty & bus.out_ready;
    assign push_req = bus.MemWrite & tx_sel;
    // A push into a full FIFO still fits when the head leaves this cycle.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

`ifdef MEM_BUS_OVERFLOW_EN
    logic ovf_q, ovf_d;
    logic ovf_clr;

    assign ovf_clr = bus.MemWrite & stat_sel & bus.WriteData[3];
    // A drop in the same cycle as a clear wins, so no overflow is missed.
    assign ovf_d   = drop | (ovf_q & ~ovf_clr);
    assign ovf     = ovf_q;

    // Sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!rst) ovf_q <= 1'b0;
        else      ovf_q <= ovf_d;
    end
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign ovf         = 1'b0;
`endif

    // Next-state for FIFO pointers, occupancy and the done flag.
    always_comb begin
        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
        cnt_d  = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        done_d = done_q | (bus.MemWrite & done_sel & bus.WriteData[0]);
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // FIFO storage; pushes in the reset cycle are ignored.
    always_ff @(posedge clk) begin
        if (rst && push) fifo_q[wptr_q] <= bus.WriteData[7:0];
    end

    // Data RAM, word writes, contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.MemWrite && ram_sel) ram_q[idx] <= bus.WriteData;
    end

    // Load data mux: RAM, STATUS, or zero for everything else.
    always_comb begin
        rdata = '0;
        unique case (1'b1)
            ram_sel:  rdata = ram_q[idx];
            stat_sel: rdata = {28'b0, ovf, done_q, full, empty};
            default:  rdata = '0;
        endcase
    end

    assign bus.ReadData  = rdata;
    assign bus.out_data  = fifo_q[rptr_q];
    assign bus.out_valid = ~empty;
    assign bus.done      = done_q;
endmodule
